// File: rtl/led_sw_pio.sv
// Switch-input / LED-output PIO on an Avalon-MM slave: debounced switches with
// edge capture and maskable irq, LEDs with per-bit steady/blink mode.
module led_sw_pio #(
  parameter int          W               = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] BLINK_RESET     = 32'd25000000
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic [2:0]   avs_address,
  input  logic         avs_read,
  input  logic         avs_write,
  input  logic [31:0]  avs_writedata,
  output logic [31:0]  avs_readdata,
  input  logic [W-1:0] sw_export,
  output logic [W-1:0] ledr_export,
  output logic         irq
);

  localparam int            TW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TICK_LOAD = TW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  sync_meta, sync, samp, deb, deb_next, stable;
  logic [W-1:0]  edge_cap, irq_mask, led_data, led_mode, wdata_w, edge_clr;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [31:0]   blink_div, blink_cnt, rdata_next;
  logic          phase;

  assign wdata_w = avs_writedata[W-1:0];
  assign tick    = (tick_cnt == '0);

  always_comb begin
    stable   = ~(sync ^ samp);
    deb_next = deb;
    if (tick) deb_next = (sync & stable) | (deb & ~stable);
    edge_clr = '0;
    if (avs_write && avs_address == 3'd1) edge_clr = wdata_w;
  end

  // Down-counter reloading to DEBOUNCE_CYCLES-1 gives the first tick
  // DEBOUNCE_CYCLES clocks after reset release.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_meta <= '0;
      sync      <= '0;
      samp      <= '0;
      deb       <= '0;
      tick_cnt  <= TICK_LOAD;
    end else begin
      sync_meta <= sw_export;
      sync      <= sync_meta;
      tick_cnt  <= tick ? TICK_LOAD : tick_cnt - 1'b1;
      if (tick) samp <= sync;
      deb <= deb_next;
    end
  end

  // Setting a bit on a debounced change takes priority over a coincident clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_cap <= '0;
      irq_mask <= '0;
      led_data <= '0;
      led_mode <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~edge_clr) | (deb_next ^ deb);
      irq      <= |(edge_cap & irq_mask);
      if (avs_write && avs_address == 3'd2) irq_mask <= wdata_w;
      if (avs_write && avs_address == 3'd3) led_data <= wdata_w;
      if (avs_write && avs_address == 3'd4) led_mode <= wdata_w;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      blink_div <= BLINK_RESET;
      blink_cnt <= BLINK_RESET;
      phase     <= 1'b0;
    end else if (avs_write && avs_address == 3'd5) begin
      blink_div <= avs_writedata;
      blink_cnt <= avs_writedata;
    end else if (blink_cnt == '0) begin
      phase     <= ~phase;
      blink_cnt <= blink_div;
    end else begin
      blink_cnt <= blink_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) ledr_export <= '0;
    else ledr_export <= (led_data & ~led_mode) | (led_data & led_mode & {W{phase}});
  end

  always_comb begin
    rdata_next = '0;
    case (avs_address)
      3'd0:    rdata_next[W-1:0] = deb;
      3'd1:    rdata_next[W-1:0] = edge_cap;
      3'd2:    rdata_next[W-1:0] = irq_mask;
      3'd3:    rdata_next[W-1:0] = led_data;
      3'd4:    rdata_next[W-1:0] = led_mode;
      3'd5:    rdata_next        = blink_div;
      default: rdata_next        = '0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rdata_next;
  end

endmodule

// File: tb/tb_led_sw_pio.sv
// Directed self-checking bench for led_sw_pio (W=8, DEBOUNCE_CYCLES=4, BLINK_RESET=3).
module tb_led_sw_pio;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [7:0]  sw_export;
  logic [7:0]  ledr_export;
  logic        irq;

  int checks = 0;
  int errors = 0;

  led_sw_pio #(.W(8), .DEBOUNCE_CYCLES(4), .BLINK_RESET(32'd3)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .sw_export(sw_export), .ledr_export(ledr_export), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  // Returns on the falling edge where reset is released; sw is already applied.
  task automatic do_reset(input logic [7:0] sw_val);
    reset_reset_n = 1'b0;
    avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
    sw_export = sw_val;
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d, exp;
    do_reset(8'h00);
    checks++;
    if (ledr_export !== 8'h00) begin errors++; $display("FAIL reset_ledr got %h want 00", ledr_export); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d);
      exp = (a == 5) ? 32'd3 : 32'd0;
      checks++;
      if (d !== exp) begin errors++; $display("FAIL reset_read addr %0d got %h want %h", a, d, exp); end
    end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    do_reset(8'h00);
    bus_write(3'd5, 32'hDEADBEEF);
    bus_read(3'd5, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL blink_div_rw got %h want deadbeef", d); end
    bus_write(3'd6, 32'hFFFFFFFF);
    bus_read(3'd6, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL addr6_read got %h want 0", d); end
    bus_write(3'd0, 32'hFFFFFFFF);
    bus_read(3'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL sw_state_ro got %h want 0", d); end
    bus_write(3'd2, 32'hFFFFFF5A);
    bus_read(3'd2, d);
    checks++;
    if (d !== 32'h5A) begin errors++; $display("FAIL irq_mask_rw got %h want 5a", d); end
  endtask

  task automatic test_debounce_accept;
    logic [31:0] d;
    int seen_at = 0;
    do_reset(8'hA5);
    for (int i = 1; i <= 6 && seen_at == 0; i++) begin
      bus_read(3'd0, d);
      if (d === 32'hA5) seen_at = i;
    end
    // Accepted at the second tick (8th edge); visible to the read sampled on edge 10.
    checks++;
    if (seen_at != 5) begin errors++; $display("FAIL debounce_latency got read %0d want read 5", seen_at); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 32'hA5) begin errors++; $display("FAIL debounce_edgecap got %h want a5", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got %b want 0", irq); end
  endtask

  task automatic test_debounce_reject;
    logic [31:0] d;
    do_reset(8'h00);
    @(negedge clk_clk);
    sw_export = 8'h01;
    repeat (2) @(negedge clk_clk);
    sw_export = 8'h00;
    repeat (20) @(negedge clk_clk);
    bus_read(3'd0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reject_sw_state got %h want 0", d); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reject_edgecap got %h want 0", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    int waited = 0;
    do_reset(8'h01);
    bus_write(3'd2, 32'h1);
    while (irq !== 1'b1 && waited < 20) begin
      @(negedge clk_clk);
      waited++;
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert got %b want 1 (timeout)", irq); end
    bus_write(3'd1, 32'h1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_one_after_clear got %b want 1", irq); end
    @(negedge clk_clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_two_after_clear got %b want 0", irq); end
    bus_read(3'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL edgecap_cleared got %h want 0", d); end
  endtask

  task automatic test_set_clear_race;
    logic [31:0] d;
    do_reset(8'h01);
    // deb[0] changes on edge 8; the clear write below is sampled on edge 8 too.
    repeat (6) @(negedge clk_clk);
    bus_write(3'd1, 32'h1);
    bus_read(3'd1, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL set_wins got %h want 1", d); end
    bus_read(3'd0, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL race_sw_state got %h want 1", d); end
  endtask

  task automatic test_steady;
    logic [31:0] d;
    do_reset(8'h00);
    bus_write(3'd3, 32'hFFFFFF3C);
    bus_write(3'd4, 32'h0);
    checks++;
    if (ledr_export !== 8'h3C) begin errors++; $display("FAIL steady_ledr got %h want 3c", ledr_export); end
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h3C) begin errors++; $display("FAIL led_data_read got %h want 3c", d); end
    do_reset(8'h00);
    bus_write(3'd3, 32'h81);
    checks++;
    if (ledr_export !== 8'h00) begin errors++; $display("FAIL ledr_latency_early got %h want 00", ledr_export); end
    @(negedge clk_clk);
    checks++;
    if (ledr_export !== 8'h81) begin errors++; $display("FAIL ledr_latency got %h want 81", ledr_export); end
    @(negedge clk_clk);
    avs_address = 3'd3; avs_writedata = 32'h55; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0; avs_write = 1'b0;
    checks++;
    if (avs_readdata !== 32'h81) begin errors++; $display("FAIL rw_same_cycle got %h want 81", avs_readdata); end
    bus_read(3'd3, d);
    checks++;
    if (d !== 32'h55) begin errors++; $display("FAIL rw_after got %h want 55", d); end
  endtask

  task automatic test_blink;
    logic [7:0] exp;
    logic       ph;
    do_reset(8'h00);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd4, 32'h0F);
    bus_write(3'd5, 32'h3);
    // Now just after edge 6; phase rose at edge 4, counter reloaded at edge 6,
    // next toggles at edges 10, 14, 18; ledr trails phase by one edge.
    for (int k = 6; k <= 21; k++) begin
      if (k <= 10) ph = 1'b1;
      else ph = (((k - 11) / 4) % 2) != 0;
      exp = ph ? 8'hFF : 8'hF0;
      checks++;
      if (ledr_export !== exp) begin errors++; $display("FAIL blink cycle %0d got %h want %h", k, ledr_export, exp); end
      @(negedge clk_clk);
    end
    #2 reset_reset_n = 1'b0;
    #1;
    checks++;
    if (ledr_export !== 8'h00) begin errors++; $display("FAIL reset_mid_blink got %h want 00", ledr_export); end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_regs();
    test_debounce_accept();
    test_debounce_reject();
    test_irq();
    test_set_clear_race();
    test_steady();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
